// File: rtl/student_bitwise_pkg.sv
// student_bitwise_pkg: shared op encoding and result-buffer state for student_bitwise_pipe
package student_bitwise_pkg;

    // Operation select, applied identically to every bit of the operands
    typedef enum logic [2:0] {
        OP_NOT_A  = 3'd0,
        OP_AND    = 3'd1,
        OP_OR     = 3'd2,
        OP_XOR    = 3'd3,
        OP_NAND   = 3'd4,
        OP_NOR    = 3'd5,
        OP_XNOR   = 3'd6,
        OP_PASS_A = 3'd7
    } op_t;

    // Occupancy of the 2-entry in-order result buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/student_bitwise_slice.sv
// student_bitwise_slice: one-bit bitwise ALU built only from nand_gate cells
//   nand_gate             : 2-input NAND primitive (a, b -> y)
//   student_bitwise_slice : a, b, op[2:0] -> y, op encoded as in student_bitwise_pkg
module nand_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module student_bitwise_slice (
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);
    logic       na, nb, n1, an, o, x2, x3, x, nr, xn;
    logic [2:0] nop;
    logic [7:0] leaf;
    logic [6:0] node;

    nand_gate u_na  (.a(a),  .b(a),  .y(na));
    nand_gate u_nb  (.a(b),  .b(b),  .y(nb));
    nand_gate u_n1  (.a(a),  .b(b),  .y(n1));
    nand_gate u_and (.a(n1), .b(n1), .y(an));
    nand_gate u_or  (.a(na), .b(nb), .y(o));
    nand_gate u_x2  (.a(a),  .b(n1), .y(x2));
    nand_gate u_x3  (.a(b),  .b(n1), .y(x3));
    nand_gate u_xor (.a(x2), .b(x3), .y(x));
    nand_gate u_nor (.a(o),  .b(o),  .y(nr));
    nand_gate u_xnr (.a(x),  .b(x),  .y(xn));

    // Leaf index equals the op code, so the mux tree below selects leaf[op]
    assign leaf = {a, xn, nr, n1, x, o, an, na};

    for (genvar j = 0; j < 3; j++) begin : g_inv
        nand_gate u_inv (.a(op[j]), .b(op[j]), .y(nop[j]));
    end

    // 8:1 mux as a tree of NAND 2:1 muxes: nodes 0-3 pick on op[0],
    // nodes 4-5 on op[1], node 6 on op[2]
    for (genvar k = 0; k < 7; k++) begin : g_mux
        localparam int L = (k < 4) ? 0 : ((k < 6) ? 1 : 2);
        logic d0, d1, p, q;
        if (k < 4) begin : g_leaf
            assign d0 = leaf[2*k];
            assign d1 = leaf[2*k+1];
        end else begin : g_inner
            assign d0 = node[2*k-8];
            assign d1 = node[2*k-7];
        end
        nand_gate u_hi (.a(d1), .b(op[L]),  .y(p));
        nand_gate u_lo (.a(d0), .b(nop[L]), .y(q));
        nand_gate u_o  (.a(p),  .b(q),      .y(node[k]));
    end

    assign y = node[6];
endmodule

// File: rtl/student_bitwise_pipe.sv
// student_bitwise_pipe: NAND-built bitwise ALU feeding a 2-entry in-order result buffer
//   clk, reset (async, active-high)
//   in_valid/in_ready, in_a, in_b, in_op : operand/op bundle handshake
//   out_valid/out_ready, out_data        : result handshake, out_data zero when idle
//   out_parity (only with STUDENT_BITWISE_PIPE_PARITY_EN) : XOR-reduction of out_data
module student_bitwise_pipe
    import student_bitwise_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef STUDENT_BITWISE_PIPE_PARITY_EN
    ,
    output logic             out_parity
`endif
);
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] mem [2];
    buf_state_t       state, state_nxt;
    logic             wr_ptr, rd_ptr, rdy_q, push, pop;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        student_bitwise_slice u_slice (.a(in_a[i]), .b(in_b[i]), .op(in_op), .y(res[i]));
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid && rdy_q;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: state_nxt = push ? ST_ONE : ST_EMPTY;
            ST_ONE:   state_nxt = (push && !pop) ? ST_FULL : ((pop && !push) ? ST_EMPTY : ST_ONE);
            ST_FULL:  state_nxt = pop ? ST_ONE : ST_FULL;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // in_ready is registered from the next state, so it drops the cycle the buffer fills
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_EMPTY;
            rdy_q  <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != ST_FULL);
            if (push)
                wr_ptr <= !wr_ptr;
            if (pop)
                rd_ptr <= !rd_ptr;
        end
    end

    // Storage needs no reset: it is only visible through out_valid-gated outputs
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= res;
    end

`ifdef STUDENT_BITWISE_PIPE_PARITY_EN
    logic [WIDTH-1:0] pc;
    logic             par_mem [2];

    // Ripple XOR chain over the computed result, each stage a 4-NAND XOR
    assign pc[0] = res[0];
    for (genvar i = 1; i < WIDTH; i++) begin : g_par
        logic n1, n2, n3;
        nand_gate u_p1 (.a(pc[i-1]), .b(res[i]), .y(n1));
        nand_gate u_p2 (.a(pc[i-1]), .b(n1),     .y(n2));
        nand_gate u_p3 (.a(res[i]),  .b(n1),     .y(n3));
        nand_gate u_p4 (.a(n2),      .b(n3),     .y(pc[i]));
    end

    always_ff @(posedge clk) begin
        if (push)
            par_mem[wr_ptr] <= pc[WIDTH-1];
    end

    assign out_parity = out_valid ? par_mem[rd_ptr] : 1'b0;
`endif
endmodule

// File: tb/tb_student_bitwise_pipe.sv
// tb_student_bitwise_pipe: scoreboard bench for student_bitwise_pipe (WIDTH 16, 1, 64)
module tb_student_bitwise_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;
    logic [2:0]  in_op = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic        wv = 1'b0;
    logic        w1_ready, w1_valid, w64_ready, w64_valid;
    logic [0:0]  w1_data;
    logic [63:0] w64_data;
    logic [0:0]  one1 = 1'b1, zero1 = 1'b0;
    logic [63:0] ones64 = '1, zero64 = '0;
`ifdef STUDENT_BITWISE_PIPE_PARITY_EN
    logic        out_parity, w1_parity, w64_parity;
`endif

    int          n_chk = 0, n_pass = 0;
    logic [15:0] q[$];
    int          cnt = 0;
    logic        rdy_exp = 1'b0, push_m, pop_m;

    always #5 clk = ~clk;

    student_bitwise_pipe #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
`ifdef STUDENT_BITWISE_PIPE_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    student_bitwise_pipe #(.WIDTH(1)) d1 (
        .clk(clk), .reset(reset), .in_valid(wv), .in_ready(w1_ready),
        .in_a(one1), .in_b(zero1), .in_op(3'd3), .out_valid(w1_valid),
        .out_ready(1'b1), .out_data(w1_data)
`ifdef STUDENT_BITWISE_PIPE_PARITY_EN
        , .out_parity(w1_parity)
`endif
    );

    student_bitwise_pipe #(.WIDTH(64)) d64 (
        .clk(clk), .reset(reset), .in_valid(wv), .in_ready(w64_ready),
        .in_a(ones64), .in_b(zero64), .in_op(3'd3), .out_valid(w64_valid),
        .out_ready(1'b1), .out_data(w64_data)
`ifdef STUDENT_BITWISE_PIPE_PARITY_EN
        , .out_parity(w64_parity)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        case (op)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Scoreboard: expected results enter on model-accepted bundles, leave on model pops
    always @(negedge clk) begin
        if (reset) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            q.delete();
            cnt = 0;
            rdy_exp = 1'b0;
        end else begin
            check("in_ready", in_ready, rdy_exp);
            check("out_valid", out_valid, cnt != 0);
            if (cnt != 0) begin
                if (q.size() == 0)
                    check("queue_empty", 1, 0);
                else begin
                    check("out_data", out_data, q[0]);
`ifdef STUDENT_BITWISE_PIPE_PARITY_EN
                    check("out_parity", out_parity, ^q[0]);
`endif
                end
            end else
                check("idle_out_data", out_data, 0);
            push_m = in_valid && rdy_exp;
            pop_m  = (cnt != 0) && out_ready;
            if (pop_m && q.size() > 0)
                void'(q.pop_front());
            if (push_m)
                q.push_back(ref_op(in_a, in_b, in_op));
            cnt = cnt + int'(push_m) - int'(pop_m);
            rdy_exp = (cnt != 2);
        end
    end

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = r;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            drive(1, 16'hF0F0, 16'hFF00, 3'(i), 1);
        repeat (3) drive(0, 0, 0, 0, 1);
        drive(1, 16'h1234, 16'h00FF, 3'd1, 0);
        drive(1, 16'hA5A5, 16'h0F0F, 3'd3, 0);
        drive(1, 16'hBEEF, 16'hFFFF, 3'd2, 0);
        repeat (2) drive(0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 1);
        drive(1, 16'h0001, 16'h0000, 3'd7, 0);
        drive(1, 16'h00F0, 16'h0F00, 3'd5, 1);
        for (int i = 0; i < 120; i++)
            drive(1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
        drive(1, 16'h5555, 16'h3333, 3'd6, 0);
        drive(1, 16'hCCCC, 16'h0F0F, 3'd4, 0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (3) drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            drive(1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
        drive(0, 0, 0, 0, 1);
        @(posedge clk);
        #1 wv = 1'b1;
        @(posedge clk);
        #1 wv = 1'b0;
        @(negedge clk);
        check("w1_valid", w1_valid, 1);
        check("w1_data", w1_data, 1);
        check("w64_valid", w64_valid, 1);
        check("w64_data", w64_data, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef STUDENT_BITWISE_PIPE_PARITY_EN
        check("w1_parity", w1_parity, 1);
        check("w64_parity", w64_parity, 0);
`endif
        @(negedge clk);
        check("w1_drained", w1_valid, 0);
        check("w64_drained", w64_valid, 0);
        for (int i = 0; i < 20 && q.size() != 0; i++)
            drive(0, 0, 0, 0, 1);
        @(negedge clk);
        check("drain", 64'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/student_bitwise_pipe.md
STUDENT_BITWISE_PIPE -- requirements
Module: student_bitwise_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits, legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 in_valid  input  1  operand/op bundle presented.
REQ-005 in_ready  output  1  block can accept a bundle this cycle.
REQ-006 in_a  input  WIDTH  operand A.
REQ-007 in_b  input  WIDTH  operand B; ignored for NOT_A and PASS_A.
REQ-008 in_op  input  3  operation select, encoded per the shared package.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_data  output  WIDTH  bitwise result.

Function
REQ-012 Op encoding: 0 NOT_A, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS_A; operation applied independently to every bit i in 0..WIDTH-1.
REQ-013 All bitwise logic is built only from nand_gate instances in generate loops; no built-in &, |, ^ or ~ on datapath bits.
REQ-014 Input transfer occurs when in_valid && in_ready at a rising clk edge; output transfer occurs when out_valid && out_ready at a rising clk edge.
REQ-015 Result computed combinationally from the inputs and written into a 2-entry in-order result buffer on input transfer; no other stage.
REQ-016 Latency: a bundle accepted at edge N with the buffer empty has out_valid=1 and its result on out_data after edge N (1 cycle).
REQ-017 Buffer states: EMPTY (count 0), ONE (count 1), FULL (count 2); in_ready = (state != FULL), registered; out_valid = (state != EMPTY).
REQ-018 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on push+pop; FULL->ONE on pop. FULL takes no push because in_ready=0.
REQ-019 Results leave in acceptance order; out_data is the oldest entry and stays stable while out_valid=1 and out_ready=0.
REQ-020 out_data is all-zeros whenever out_valid=0.
REQ-021 in_valid while in_ready=0 has no effect; the bundle is not stored.
REQ-022 Sustained in_valid=1 and out_ready=1 gives one transfer per cycle in each direction.

Reset
REQ-023 While reset=1, outputs are in_ready=0, out_valid=0, out_data=0, with state EMPTY. Optional out_parity is 0.
REQ-024 The first clk edge after reset deasserts sets in_ready=1.
REQ-025 Reset asserted mid-operation discards all buffered results; no stale result appears after release.

Configuration
REQ-026 Macro STUDENT_BITWISE_PIPE_PARITY_EN, when defined, adds port out_parity (output, 1 bit) = XOR-reduction of out_data, stored per entry and built from nand_gate instances. It is 0 when out_valid=0.
REQ-027 When STUDENT_BITWISE_PIPE_PARITY_EN is undefined, the out_parity port and its logic are absent; all other behaviour is identical.

Structure
REQ-028 Package student_bitwise_pkg holds the 3-bit op typedef, the eight op constants, and the buffer state typedef/constants.
REQ-029 Sub-module student_bitwise_slice (one bit: a, b, op -> y, from nand_gate only) is instantiated WIDTH times via generate.
REQ-030 Buffer control and storage live in the top module; no further sub-modules.

Verification
REQ-031 Setup WIDTH=16, out_ready=1. Push a=16'hF0F0, b=16'hFF00 with ops 0..7. Expect results 0F0F, F000, FFF0, 0FF0, 0FFF, 000F, F00F, F0F0 in order, each 1 cycle after acceptance.
REQ-032 Setup out_ready=0. Push 3 bundles. Expect in_ready=0 after 2 accepts, the third not stored, and out_data holding the first result. Raise out_ready: 2 results drain in order, then in_ready=1.
REQ-033 Setup buffer at ONE. Push and pop in the same cycle. Expect state to stay ONE, out_data to become the new result, and no loss or duplication over 100 cycles of random valid/ready.
REQ-034 Setup buffer FULL. Assert reset for 1 cycle asynchronously between edges. Expect out_valid=0 and out_data=0 immediately, and in_ready=1 one edge after release with no old data emitted.
REQ-035 Setup WIDTH=1 and WIDTH=64. Push a=all-ones, b=0, op XOR. Expect all-ones; with STUDENT_BITWISE_PIPE_PARITY_EN, out_parity=1 for WIDTH=1 and 0 for WIDTH=64.
